// File: rtl/haze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : haze_pkg
// Description : Shared types and constants for the haze-removal pipeline.
//               PIX_W   - width of one pixel sample
//               PIX_MAX - brightest pixel value
//               state_t - frame-tracking state (IDLE / ACTIVE)
// Revision    : 1.0 - initial release
// ============================================================================
package haze_pkg;

    localparam int PIX_W = 8;
    localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/line_buf.sv
`default_nettype none
// ============================================================================
// Module      : line_buf
// Description : One line of pixel storage. Combinational read, synchronous
//               write on wr_en; a same-address write returns the old word on
//               rd_data during that cycle (read-before-write).
//               clk     - clock
//               wr_en   - write strobe
//               addr    - shared read/write address (pixel column)
//               wr_data - word to store
//               rd_data - word currently stored at addr
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf #(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    // Contents are deliberately never cleared; consumers mask stale words.
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign rd_data = r_mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/min3.sv
`default_nettype none
// ============================================================================
// Module      : min3
// Description : Combinational unsigned minimum of three operands.
//               a, b, c - operands
//               y       - min(a, b, c)
// Revision    : 1.0 - initial release
// ============================================================================
module min3
    import haze_pkg::*;
#(
    parameter int WIDTH = PIX_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] w_ab;

    always_comb begin
        w_ab = (a < b) ? a : b;
        y    = (w_ab < c) ? w_ab : c;
    end

endmodule
`default_nettype wire

// File: rtl/dark_channel_patch_min.sv
`default_nettype none
// ============================================================================
// Module      : dark_channel_patch_min
// Description : Streaming 3x3 patch-minimum filter (dark-channel stage).
//               Emits the minimum of every fully interior 3x3 window, one
//               cycle after the beat that completes it; borders are dropped.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               in_valid  - input beat valid (gaps allowed, no backpressure)
//               in_sof    - first pixel of frame, qualified by in_valid
//               in_pix    - per-pixel RGB-minimum value
//               out_valid - patch-minimum beat valid
//               out_pix   - minimum of 3x3 window centred on (x-1, y-1)
//               out_eof   - set with the last output of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module dark_channel_patch_min
    import haze_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_eof
);

    localparam int c_XW = $clog2(IMG_W);
    localparam int c_YW = $clog2(IMG_H);
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_H - 1);
    localparam logic [c_XW-1:0] c_X_TWO  = c_XW'(2);
    localparam logic [c_YW-1:0] c_Y_TWO  = c_YW'(2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_XW-1:0]  r_x;
    logic [c_YW-1:0]  r_y;
    logic [c_XW-1:0]  w_x_nxt;
    logic [c_YW-1:0]  w_y_nxt;
    logic [c_XW-1:0]  w_x;
    logic [c_YW-1:0]  w_y;
    logic             w_accept;
    logic             w_emit;
    logic             w_last;

    logic [PIX_W-1:0] w_lb1;
    logic [PIX_W-1:0] w_lb2;
    logic [PIX_W-1:0] w_col_min;
    logic [PIX_W-1:0] w_win;
    logic [PIX_W-1:0] r_cm1;
    logic [PIX_W-1:0] r_cm2;

    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_pix;
    logic             r_out_eof;

    // ------------------------------------------------------------------
    // Next-state / coordinate logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;

        // A sof beat is always pixel (0,0), even in the middle of a frame.
        w_accept = in_valid && (in_sof || (r_state == ACTIVE));
        w_x      = (in_valid && in_sof) ? '0 : r_x;
        w_y      = (in_valid && in_sof) ? '0 : r_y;

        w_emit = w_accept && (w_x >= c_X_TWO) && (w_y >= c_Y_TWO);
        w_last = w_accept && (w_x == c_X_LAST) && (w_y == c_Y_LAST);

        if (w_accept) begin
            if (w_last) begin
                w_state_nxt = IDLE;
                w_x_nxt     = '0;
                w_y_nxt     = '0;
            end else begin
                w_state_nxt = ACTIVE;
                if (w_x == c_X_LAST) begin
                    w_x_nxt = '0;
                    w_y_nxt = w_y + c_YW'(1);
                end else begin
                    w_x_nxt = w_x + c_XW'(1);
                    w_y_nxt = w_y;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds row y-1, lb2 holds row y-2. Each accepted
    // beat pushes the column down by one row at address x.
    // ------------------------------------------------------------------
    line_buf #(
        .DEPTH  (IMG_W),
        .WIDTH  (PIX_W),
        .ADDR_W (c_XW)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (w_accept),
        .addr    (w_x),
        .wr_data (in_pix),
        .rd_data (w_lb1)
    );

    line_buf #(
        .DEPTH  (IMG_W),
        .WIDTH  (PIX_W),
        .ADDR_W (c_XW)
    ) u_lb2 (
        .clk     (clk),
        .wr_en   (w_accept),
        .addr    (w_x),
        .wr_data (w_lb1),
        .rd_data (w_lb2)
    );

    // Vertical minimum of the current column, then horizontal minimum over
    // this column and the two before it.
    min3 #(.WIDTH(PIX_W)) u_col_min (
        .a (in_pix),
        .b (w_lb1),
        .c (w_lb2),
        .y (w_col_min)
    );

    min3 #(.WIDTH(PIX_W)) u_win_min (
        .a (w_col_min),
        .b (r_cm1),
        .c (r_cm2),
        .y (w_win)
    );

    // Column-minimum history is not reset: it only matters once x >= 2,
    // by which point both entries belong to the current row.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_cm2 <= r_cm1;
            r_cm1 <= w_col_min;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
            r_out_eof   <= 1'b0;
        end else begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_out_valid <= w_emit;
            r_out_pix   <= w_emit ? w_win : '0;
            r_out_eof   <= w_emit && w_last;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pix   = r_out_pix;
    assign out_eof   = r_out_eof;

endmodule
`default_nettype wire

// File: tb/tb_dark_channel_patch_min.sv
`default_nettype none
// ============================================================================
// Module      : tb_dark_channel_patch_min
// Description : Self-checking bench for dark_channel_patch_min. Two DUTs
//               (4x3 and 4x4 frames) share one input stream; a frame-array
//               reference model predicts every output beat and its cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dark_channel_patch_min;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_pix;

    logic       out_valid_a, out_eof_a, out_valid_b, out_eof_b;
    logic [7:0] out_pix_a, out_pix_b;

    dark_channel_patch_min #(.IMG_W(4), .IMG_H(3)) dut_a (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_sof (in_sof),
        .in_pix (in_pix), .out_valid (out_valid_a), .out_pix (out_pix_a),
        .out_eof (out_eof_a)
    );

    dark_channel_patch_min #(.IMG_W(4), .IMG_H(4)) dut_b (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_sof (in_sof),
        .in_pix (in_pix), .out_valid (out_valid_b), .out_pix (out_pix_b),
        .out_eof (out_eof_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  pix;
        logic        eof;
    } ev_t;

    ev_t exp_a[$], exp_b[$], act_a[$], act_b[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   bad_gap = 0;
    logic pv     = 1'b0;

    // Reference model state: whole frame images, one per geometry.
    logic [7:0] img [2][4][4];
    bit         act [2];
    int         mx  [2];
    int         my  [2];
    int         gw  [2] = '{4, 4};
    int         gh  [2] = '{3, 4};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pv  <= in_valid;
    end

    always @(negedge clk) begin
        if (out_valid_a === 1'b1) act_a.push_back('{cyc, out_pix_a, out_eof_a});
        if (out_valid_b === 1'b1) act_b.push_back('{cyc, out_pix_b, out_eof_b});
        if ((out_valid_a === 1'b1 || out_valid_b === 1'b1) && pv !== 1'b1) bad_gap++;
    end

    task automatic model_step(input bit r, input bit v, input bit s, input logic [7:0] p);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                act[k] = 1'b0; mx[k] = 0; my[k] = 0;
            end else if (v && (s || act[k])) begin
                logic [7:0] m;
                bit         last;
                if (s) begin
                    act[k] = 1'b1; mx[k] = 0; my[k] = 0;
                end
                img[k][my[k]][mx[k]] = p;
                last = (mx[k] == gw[k] - 1) && (my[k] == gh[k] - 1);
                if (mx[k] >= 2 && my[k] >= 2) begin
                    m = 8'hFF;
                    for (int dy = 0; dy < 3; dy++)
                        for (int dx = 0; dx < 3; dx++)
                            if (img[k][my[k]-dy][mx[k]-dx] < m) m = img[k][my[k]-dy][mx[k]-dx];
                    if (k == 0) exp_a.push_back('{cyc, m, last});
                    else        exp_b.push_back('{cyc, m, last});
                end
                if (last) begin
                    act[k] = 1'b0; mx[k] = 0; my[k] = 0;
                end else if (mx[k] == gw[k] - 1) begin
                    mx[k] = 0; my[k]++;
                end else begin
                    mx[k]++;
                end
            end
        end
    endtask

    // One clock of stimulus; the model sees the beat in the period its
    // result must appear in.
    task automatic drive(input bit r, input bit v, input bit s, input logic [7:0] p);
        rst = r; in_valid = v; in_sof = s; in_pix = p;
        @(posedge clk);
        #1;
        model_step(r, v, s, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_q();
        exp_a.delete(); exp_b.delete(); act_a.delete(); act_b.delete();
    endtask

    task automatic send_ramp(input bit gap);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) begin
                drive(1'b0, 1'b1, (x == 0 && y == 0), 8'(10 * y + x + 1));
                if (gap) idle(1);
            end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, (i == 1), 8'($urandom));
            checks++;
            if ({out_valid_a, out_pix_a, out_eof_a, out_valid_b, out_pix_b, out_eof_b} !== 20'h0) begin
                errors++;
                $display("FAIL reset_outputs: got a=%b/%h/%b b=%b/%h/%b required all zero",
                         out_valid_a, out_pix_a, out_eof_a, out_valid_b, out_pix_b, out_eof_b);
            end
        end
        clear_q();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
        idle(2);
        checks++;
        if (act_a.size() + act_b.size() != 0) begin
            errors++;
            $display("FAIL reset_no_sof: got %0d outputs required 0", act_a.size() + act_b.size());
        end
    endtask

    task automatic test_ramp();
        int last_cyc;
        clear_q();
        send_ramp(1'b0);
        last_cyc = cyc;
        idle(2);
        checks++;
        if (act_a.size() != 2) begin
            errors++;
            $display("FAIL ramp_count: got %0d required 2", act_a.size());
        end else begin
            checks++;
            if (act_a[0].pix !== 8'd1 || act_a[1].pix !== 8'd2 || act_a[0].eof !== 1'b0 ||
                act_a[1].eof !== 1'b1 || act_a[1].cyc != last_cyc) begin
                errors++;
                $display("FAIL ramp_values: got %0d/%b %0d/%b@%0d required 1/0 2/1@%0d",
                         act_a[0].pix, act_a[0].eof, act_a[1].pix, act_a[1].eof, act_a[1].cyc, last_cyc);
            end
        end
        for (int k = 0; k < 2; k++) begin
            ev_t e[$], a[$];
            if (k == 0) begin e = exp_a; a = act_a; end else begin e = exp_b; a = act_b; end
            checks++;
            if (a.size() != e.size()) begin
                errors++;
                $display("FAIL ramp_model_count dut%0d: got %0d required %0d", k, a.size(), e.size());
            end
            for (int i = 0; i < e.size() && i < a.size(); i++) begin
                checks++;
                if (a[i] !== e[i]) begin
                    errors++;
                    $display("FAIL ramp_model dut%0d #%0d: got cyc=%0d pix=%0d eof=%b required cyc=%0d pix=%0d eof=%b",
                             k, i, a[i].cyc, a[i].pix, a[i].eof, e[i].cyc, e[i].pix, e[i].eof);
                end
            end
        end
    endtask

    task automatic test_dark_pixel();
        clear_q();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                drive(1'b0, 1'b1, (x == 0 && y == 0), (x == 3 && y == 3) ? 8'd0 : 8'd255);
        idle(2);
        checks++;
        if (act_b.size() != 4) begin
            errors++;
            $display("FAIL dark_count: got %0d required 4", act_b.size());
        end else begin
            checks++;
            if ({act_b[0].pix, act_b[1].pix, act_b[2].pix, act_b[3].pix} !== 32'hFFFFFF00 ||
                {act_b[0].eof, act_b[1].eof, act_b[2].eof, act_b[3].eof} !== 4'b0001) begin
                errors++;
                $display("FAIL dark_values: got %0d %0d %0d %0d eof=%b%b%b%b required 255 255 255 0 eof=0001",
                         act_b[0].pix, act_b[1].pix, act_b[2].pix, act_b[3].pix,
                         act_b[0].eof, act_b[1].eof, act_b[2].eof, act_b[3].eof);
            end
        end
        for (int k = 0; k < 2; k++) begin
            ev_t e[$], a[$];
            if (k == 0) begin e = exp_a; a = act_a; end else begin e = exp_b; a = act_b; end
            checks++;
            if (a.size() != e.size()) begin
                errors++;
                $display("FAIL dark_model_count dut%0d: got %0d required %0d", k, a.size(), e.size());
            end
            for (int i = 0; i < e.size() && i < a.size(); i++) begin
                checks++;
                if (a[i] !== e[i]) begin
                    errors++;
                    $display("FAIL dark_model dut%0d #%0d: got cyc=%0d pix=%0d eof=%b required cyc=%0d pix=%0d eof=%b",
                             k, i, a[i].cyc, a[i].pix, a[i].eof, e[i].cyc, e[i].pix, e[i].eof);
                end
            end
        end
    endtask

    task automatic test_gapped();
        clear_q();
        bad_gap = 0;
        send_ramp(1'b1);
        idle(2);
        checks++;
        if (act_a.size() != 2 || (act_a.size() == 2 && (act_a[0].pix !== 8'd1 || act_a[1].pix !== 8'd2))) begin
            errors++;
            $display("FAIL gapped_values: got %0d outputs required 2 outputs 1,2", act_a.size());
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL gapped_valid_after_gap: got %0d required 0", bad_gap);
        end
        for (int k = 0; k < 2; k++) begin
            ev_t e[$], a[$];
            if (k == 0) begin e = exp_a; a = act_a; end else begin e = exp_b; a = act_b; end
            checks++;
            if (a.size() != e.size()) begin
                errors++;
                $display("FAIL gapped_model_count dut%0d: got %0d required %0d", k, a.size(), e.size());
            end
            for (int i = 0; i < e.size() && i < a.size(); i++) begin
                checks++;
                if (a[i] !== e[i]) begin
                    errors++;
                    $display("FAIL gapped_model dut%0d #%0d: got cyc=%0d pix=%0d eof=%b required cyc=%0d pix=%0d eof=%b",
                             k, i, a[i].cyc, a[i].pix, a[i].eof, e[i].cyc, e[i].pix, e[i].eof);
                end
            end
        end
    endtask

    task automatic test_restart();
        int n_eof;
        clear_q();
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, (i == 0), 8'(10 * (i / 4) + (i % 4) + 1));
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, (i == 0), 8'd7);
        idle(2);
        n_eof = 0;
        foreach (act_a[i]) if (act_a[i].eof === 1'b1) n_eof++;
        checks++;
        if (act_a.size() != 2 || n_eof != 1 ||
            (act_a.size() == 2 && (act_a[0].pix !== 8'd7 || act_a[1].pix !== 8'd7))) begin
            errors++;
            $display("FAIL restart_values: got %0d outputs %0d eof required 2 outputs of 7, 1 eof",
                     act_a.size(), n_eof);
        end
        for (int k = 0; k < 2; k++) begin
            ev_t e[$], a[$];
            if (k == 0) begin e = exp_a; a = act_a; end else begin e = exp_b; a = act_b; end
            checks++;
            if (a.size() != e.size()) begin
                errors++;
                $display("FAIL restart_model_count dut%0d: got %0d required %0d", k, a.size(), e.size());
            end
            for (int i = 0; i < e.size() && i < a.size(); i++) begin
                checks++;
                if (a[i] !== e[i]) begin
                    errors++;
                    $display("FAIL restart_model dut%0d #%0d: got cyc=%0d pix=%0d eof=%b required cyc=%0d pix=%0d eof=%b",
                             k, i, a[i].cyc, a[i].pix, a[i].eof, e[i].cyc, e[i].pix, e[i].eof);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_after;
        clear_q();
        send_ramp(1'b0);
        idle(1);
        n_after = act_a.size();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 5)));
        idle(1);
        checks++;
        if (act_a.size() != n_after) begin
            errors++;
            $display("FAIL post_frame_no_output: got %0d extra outputs required 0", act_a.size() - n_after);
        end
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, (i == 0), 8'($urandom_range(20, 255)));
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, (i == 0), 8'($urandom_range(20, 255)));
        idle(2);
        checks++;
        if (act_a.size() != 6) begin
            errors++;
            $display("FAIL back_to_back_count: got %0d required 6", act_a.size());
        end
        for (int k = 0; k < 2; k++) begin
            ev_t e[$], a[$];
            if (k == 0) begin e = exp_a; a = act_a; end else begin e = exp_b; a = act_b; end
            checks++;
            if (a.size() != e.size()) begin
                errors++;
                $display("FAIL b2b_model_count dut%0d: got %0d required %0d", k, a.size(), e.size());
            end
            for (int i = 0; i < e.size() && i < a.size(); i++) begin
                checks++;
                if (a[i] !== e[i]) begin
                    errors++;
                    $display("FAIL b2b_model dut%0d #%0d: got cyc=%0d pix=%0d eof=%b required cyc=%0d pix=%0d eof=%b",
                             k, i, a[i].cyc, a[i].pix, a[i].eof, e[i].cyc, e[i].pix, e[i].eof);
                end
            end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int i = 0; i < 600; i++) begin
            bit r, v, s;
            r = ($urandom_range(0, 249) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = v && ($urandom_range(0, 17) == 0);
            drive(r, v, s, 8'($urandom));
        end
        idle(2);
        for (int k = 0; k < 2; k++) begin
            ev_t e[$], a[$];
            if (k == 0) begin e = exp_a; a = act_a; end else begin e = exp_b; a = act_b; end
            checks++;
            if (a.size() != e.size()) begin
                errors++;
                $display("FAIL random_model_count dut%0d: got %0d required %0d", k, a.size(), e.size());
            end
            for (int i = 0; i < e.size() && i < a.size(); i++) begin
                checks++;
                if (a[i] !== e[i]) begin
                    errors++;
                    $display("FAIL random_model dut%0d #%0d: got cyc=%0d pix=%0d eof=%b required cyc=%0d pix=%0d eof=%b",
                             k, i, a[i].cyc, a[i].pix, a[i].eof, e[i].cyc, e[i].pix, e[i].eof);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = 8'h00;
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; mx[k] = 0; my[k] = 0;
        end
        test_reset();
        test_ramp();
        test_dark_pixel();
        test_gapped();
        test_restart();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
